// File: rtl/queue_pkg.sv
// Shared helpers for the parametrised queue: address-width derivation and
// wrap-bit pointer comparisons.
package queue_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // A depth of 1 would give a zero-width address; keep at least one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

    function automatic logic is_empty(input logic [31:0] ra, input logic [31:0] wa);
        return ra == wa;
    endfunction

    // Full when address bits match and only the wrap bit (bit aw) differs.
    function automatic logic is_full(input logic [31:0] ra, input logic [31:0] wa,
                                     input int unsigned aw);
        return (ra ^ wa) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/queue_dpram.sv
// WIDTH x DEPTH distributed RAM: synchronous write, asynchronous read.
module queue_dpram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= din;
        end
    end

    assign dout = mem[ra];

endmodule

// File: rtl/queue_param.sv
// Parametrised first-word-fall-through queue with full/almost-full flags and
// occupancy count. Define QUEUE_ERR_EN to add sticky overflow/underflow outputs.
module queue_param
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [AW:0]      count
`ifdef QUEUE_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] ra;
    logic [AW:0] wa;
    logic        push_ok;
    logic        pop_ok;

    assign empty       = is_empty(32'(ra), 32'(wa));
    assign full        = is_full(32'(ra), 32'(wa), AW);
    assign count       = wa - ra;
    assign almost_full = (32'(count) >= AF_LEVEL);

    // A pop on a full queue frees the slot the simultaneous push lands in.
    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            wa <= '0;
        end else begin
            if (push_ok) begin
                wa <= wa + PTR_ONE;
            end
            if (pop_ok) begin
                ra <= ra + PTR_ONE;
            end
        end
    end

    queue_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dpram (
        .clk  (clk),
        .we   (push_ok),
        .wa   (wa[AW-1:0]),
        .din  (din),
        .ra   (ra[AW-1:0]),
        .dout (dout)
    );

`ifdef QUEUE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/queue_param.md
Name: queue_param

Overview:
- Parametrised successor of the fixed 32-bit, 64-entry distributed-RAM queue.
- Configurable width and depth; adds a true full flag, an occupancy count and an almost-full threshold.
- Drops illegal pushes and pops instead of corrupting the pointers.
- Sits between RISC-core producers and consumers (message/ring queues). dout is combinational from storage (first-word-fall-through).

Parameters:
- WIDTH, 32, data width in bits, >=1.
- DEPTH, 64, number of entries; power of 2, >=2.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  push request.
- rd_en  in  1  pop request; dout is consumed in the cycle rd_en is high.
- dout  out  WIDTH  head-of-queue data; undefined while empty=1.
- empty  out  1  queue holds 0 entries.
- full  out  1  queue holds DEPTH entries.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  AW+1  current occupancy 0..DEPTH, where AW = clog2(DEPTH).

Behaviour:
- Pointers
  - ra and wa are AW+1 bits wide, with the MSB acting as a wrap bit.
  - empty = (ra == wa).
  - full = address bits equal and wrap bits differ.
  - count = wa - ra, modulo 2^(AW+1).
- Reset: ra = wa = 0, so empty=1, full=0, count=0, almost_full=0. Storage contents are not cleared. Reset overrides wr_en/rd_en in the same cycle.
- Accepted push (push_ok) = wr_en & (~full | rd_en). Storage is written at address wa[AW-1:0] and wa increments, wrapping naturally.
- Accepted pop (pop_ok) = rd_en & ~empty. ra increments.
- Simultaneous push and pop:
  - When empty: the pop is dropped and the push is accepted. Next cycle count=1 and dout=din.
  - When full: both are accepted. dout this cycle is the old head; the write lands in the freed slot; count stays DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- Dropped operations (push when full without rd_en, pop when empty) leave all state unchanged.
- Latency:
  - A write is visible on dout the cycle after the push edge, if the queue was empty.
  - Flags and count are registered-pointer derived and update one cycle after the accepting edge.
- dout = mem[ra[AW-1:0]], an asynchronous read with no output register.
- Wrap-around: after 2*DEPTH pushes and pops the pointers return to 0 with no flag glitch. Only the pointer compare matters.

Optional Feature:
- Macro: QUEUE_ERR_EN.
- Defined:
  - Adds output ports overflow (1) and underflow (1).
  - overflow sets on a dropped push (wr_en & full & ~rd_en); underflow sets on a dropped pop (rd_en & empty).
  - Both are sticky until rst and reset to 0.
- Undefined: the ports are absent and dropped operations are silent. Core behaviour is identical in both builds.

Decomposition:
- Package queue_pkg: clog2 constant function; localparam AW derivation helper; pointer-compare helper functions is_empty/is_full.
- Sub-module queue_dpram:
  - WIDTH x DEPTH distributed RAM with synchronous write (we, wa, din) and asynchronous read (ra -> dout).
  - One instance replaces the per-bit dpram64 array.

Test Plan (WIDTH=32, DEPTH=64, AF_LEVEL=60):
1. Reset, then one push of 0xDEADBEEF -> next cycle empty=0, count=1, dout=0xDEADBEEF; pop -> empty=1, count=0.
2. 64 pushes of 0..63 -> full=1 and count=64 after the last; almost_full rises on the cycle count becomes 60. A 65th push of 0xFFFFFFFF is dropped and count stays 64. Then 64 pops return 0..63 in order.
3. Full queue, push 0xA5A5A5A5 with a simultaneous pop -> dout showed the old head that cycle, count stays 64, and 0xA5A5A5A5 emerges last.
4. Empty queue, rd_en=1 with wr_en=1 din=7 -> count=1 and dout=7. Pop on empty alone -> no state change; underflow=1 when QUEUE_ERR_EN is defined.
5. Stream 200 words with random push/pop mixes through more than 3 wraps -> a scoreboard matches order and count every cycle; full and empty are never both 1.
6. Assert rst mid-stream with count=17 -> next cycle count=0 and empty=1; overflow/underflow cleared; a following push and pop round-trips correctly.
